// File: rtl/hex_display_scan.sv
// ============================================================================
// Module   : hex_display_scan
// Purpose  : Multiplexed hex display scanner with frame-synchronous update
//            and optional leading-zero suppression.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_display_scan #(
  parameter int NDIG = 4,
  parameter int DIV  = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                load,
  input  logic [4*NDIG-1:0]   value,
  input  logic [NDIG-1:0]     dp,
  input  logic                lz,
  output logic [6:0]          seg,
  output logic                dp_n,
  output logic [NDIG-1:0]     an,
  output logic                pend
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] C_CNT_MAX = CW'(DIV - 1);
  localparam logic [IW-1:0] C_IDX_MAX = IW'(NDIG - 1);
  localparam logic [6:0]    C_SEG_OFF = 7'h7F;

  logic [CW-1:0]     count_q, count_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] active_q, active_d, shadow_q, shadow_d;
  logic [NDIG-1:0]   active_dp_q, active_dp_d, shadow_dp_q, shadow_dp_d;
  logic              pend_q, pend_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_n_q, dp_n_d;
  logic [NDIG-1:0]   an_q, an_d;

  logic              tick, wrap;
  logic              upper_nz;
  logic [NDIG-1:0]   blank_vec;
  logic [3:0]        sel_nib;
  logic              sel_dp;
  logic              sel_blank;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  assign tick = en && (count_q == C_CNT_MAX);
  assign wrap = tick && (idx_q == C_IDX_MAX);

  // A digit is suppressible when it and every more-significant digit is zero.
  always_comb begin
    upper_nz  = 1'b0;
    blank_vec = '0;
    for (int k = NDIG - 1; k >= 0; k--) begin
      upper_nz     = upper_nz | (|active_q[4*k +: 4]);
      blank_vec[k] = lz && !upper_nz && (k != 0);
    end
  end

  always_comb begin
    sel_nib   = 4'h0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (idx_q == IW'(k)) begin
        sel_nib   = active_q[4*k +: 4];
        sel_dp    = active_dp_q[k];
        sel_blank = blank_vec[k];
      end
    end
  end

  always_comb begin
    count_d     = count_q;
    idx_d       = idx_q;
    active_d    = active_q;
    active_dp_d = active_dp_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    pend_d      = pend_q;

    if (en) begin
      count_d = tick ? '0 : count_q + 1'b1;
    end
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end

    // Apply only at the frame boundary so a frame never mixes old and new data;
    // a coincident load re-arms pend with the fresh shadow contents.
    if (wrap && pend_q) begin
      active_d    = shadow_q;
      active_dp_d = shadow_dp_q;
      pend_d      = 1'b0;
    end
    if (load) begin
      shadow_d    = value;
      shadow_dp_d = dp;
      pend_d      = 1'b1;
    end

    if (!en || sel_blank) begin
      seg_d  = C_SEG_OFF;
      dp_n_d = 1'b1;
      an_d   = '1;
    end else begin
      seg_d  = hex_to_seg(sel_nib);
      dp_n_d = ~sel_dp;
      an_d   = ~(NDIG'(1) << idx_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      idx_q       <= '0;
      active_q    <= '0;
      active_dp_q <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      pend_q      <= 1'b0;
      seg_q       <= C_SEG_OFF;
      dp_n_q      <= 1'b1;
      an_q        <= '1;
    end else begin
      count_q     <= count_d;
      idx_q       <= idx_d;
      active_q    <= active_d;
      active_dp_q <= active_dp_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      pend_q      <= pend_d;
      seg_q       <= seg_d;
      dp_n_q      <= dp_n_d;
      an_q        <= an_d;
    end
  end

  assign seg  = seg_q;
  assign dp_n = dp_n_q;
  assign an   = an_q;
  assign pend = pend_q;

endmodule

`default_nettype wire

// File: tb/tb_hex_display_scan.sv
// ============================================================================
// Module   : tb_hex_display_scan
// Purpose  : Directed self-checking bench for hex_display_scan (NDIG=4, DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hex_display_scan;

  localparam int NDIG = 4;
  localparam int DIV  = 4;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              load;
  logic [4*NDIG-1:0] value;
  logic [NDIG-1:0]   dp;
  logic              lz;
  logic [6:0]        seg;
  logic              dp_n;
  logic [NDIG-1:0]   an;
  logic              pend;

  int n_checks;
  int n_fail;
  int ecnt;

  hex_display_scan #(.NDIG(NDIG), .DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .load  (load),
    .value (value),
    .dp    (dp),
    .lz    (lz),
    .seg   (seg),
    .dp_n  (dp_n),
    .an    (an),
    .pend  (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp_v, ecnt);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] an_e,
                            input logic [6:0] seg_e, input logic dpn_e);
    check($sformatf("%s.an", tag), 32'(an), 32'(an_e));
    check($sformatf("%s.seg", tag), 32'(seg), 32'(seg_e));
    check($sformatf("%s.dp_n", tag), 32'(dp_n), 32'(dpn_e));
  endtask

  // Advance one rising edge and return at the following falling edge.
  task automatic tick1();
    @(posedge clk);
    ecnt++;
    @(negedge clk);
  endtask

  task automatic to_edge(input int n);
    while (ecnt < n) tick1();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    load  = 1'b1;
    value = v;
    dp    = d;
    tick1();
    load  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ecnt     = 0;
    rst_n    = 1'b0;
    en       = 1'b1;
    load     = 1'b0;
    value    = '0;
    dp       = '0;
    lz       = 1'b0;

    repeat (3) @(negedge clk);
    expect_out("reset", 4'hF, 7'h7F, 1'b1);
    check("reset.pend", 32'(pend), 32'd0);
    rst_n = 1'b1;

    // Plain scan of an all-zero value
    to_edge(1);  expect_out("scan0", 4'hE, 7'h40, 1'b1);
    to_edge(5);  expect_out("scan1", 4'hD, 7'h40, 1'b1);
    to_edge(9);  expect_out("scan2", 4'hB, 7'h40, 1'b1);
    to_edge(13); expect_out("scan3", 4'h7, 7'h40, 1'b1);
    to_edge(17); expect_out("scan0b", 4'hE, 7'h40, 1'b1);

    // Mid-frame load held until the frame boundary
    do_load(16'h12AF, 4'b0010);
    check("ld1.pend", 32'(pend), 32'd1);
    to_edge(31);
    check("ld1.pend_hold", 32'(pend), 32'd1);
    expect_out("ld1.old3", 4'h7, 7'h40, 1'b1);
    to_edge(32);
    check("ld1.pend_clr", 32'(pend), 32'd0);
    expect_out("ld1.old3b", 4'h7, 7'h40, 1'b1);
    to_edge(33); expect_out("ld1.d0", 4'hE, 7'h0E, 1'b1);
    to_edge(37); expect_out("ld1.d1", 4'hD, 7'h08, 1'b0);
    to_edge(41); expect_out("ld1.d2", 4'hB, 7'h24, 1'b1);
    to_edge(45); expect_out("ld1.d3", 4'h7, 7'h79, 1'b1);

    // Two loads in one frame: only the last is applied
    to_edge(49);
    do_load(16'h1111, 4'b0000);
    to_edge(53);
    do_load(16'h2222, 4'b0000);
    check("ld2.pend", 32'(pend), 32'd1);
    to_edge(57); expect_out("ld2.stillold", 4'hB, 7'h24, 1'b1);
    to_edge(65); expect_out("ld2.d0", 4'hE, 7'h24, 1'b1);
    check("ld2.pend_clr", 32'(pend), 32'd0);
    to_edge(69); expect_out("ld2.d1", 4'hD, 7'h24, 1'b1);
    to_edge(77); expect_out("ld2.d3", 4'h7, 7'h24, 1'b1);

    // Leading-zero suppression; second load coincides with the applying tick
    lz = 1'b1;
    do_load(16'h0050, 4'b1000);
    tick1();
    do_load(16'h0000, 4'b0000);
    check("lz.pend_coinc", 32'(pend), 32'd1);
    to_edge(81); expect_out("lz50.d0", 4'hE, 7'h40, 1'b1);
    to_edge(85); expect_out("lz50.d1", 4'hD, 7'h12, 1'b1);
    to_edge(89); expect_out("lz50.d2", 4'hF, 7'h7F, 1'b1);
    to_edge(93); expect_out("lz50.d3", 4'hF, 7'h7F, 1'b1);
    to_edge(95); check("lz.pend_hold", 32'(pend), 32'd1);
    to_edge(96); check("lz.pend_clr", 32'(pend), 32'd0);
    to_edge(97);  expect_out("lz0.d0", 4'hE, 7'h40, 1'b1);
    to_edge(101); expect_out("lz0.d1", 4'hF, 7'h7F, 1'b1);
    to_edge(109); expect_out("lz0.d3", 4'hF, 7'h7F, 1'b1);

    // Enable pause mid-digit freezes index and prescaler
    lz = 1'b0;
    to_edge(113); expect_out("en.before", 4'hE, 7'h40, 1'b1);
    en = 1'b0;
    tick1();      expect_out("en.dark0", 4'hF, 7'h7F, 1'b1);
    to_edge(123); expect_out("en.dark9", 4'hF, 7'h7F, 1'b1);
    en = 1'b1;
    tick1();      expect_out("en.resume", 4'hE, 7'h40, 1'b1);
    to_edge(126); expect_out("en.same", 4'hE, 7'h40, 1'b1);
    to_edge(127); expect_out("en.next", 4'hD, 7'h40, 1'b1);

    // Asynchronous reset discards pending data
    do_load(16'h1234, 4'b1111);
    check("rst.pend_pre", 32'(pend), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    expect_out("rst.async", 4'hF, 7'h7F, 1'b1);
    check("rst.pend", 32'(pend), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ecnt  = 0;
    to_edge(1);  expect_out("rst.first", 4'hE, 7'h40, 1'b1);
    to_edge(33); expect_out("rst.d0", 4'hE, 7'h40, 1'b1);
    check("rst.pend_post", 32'(pend), 32'd0);
    to_edge(37); expect_out("rst.d1", 4'hD, 7'h40, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
